// File: rtl/adc_seq_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adc_seq_pkg : state encoding and width helpers for the ADC sequencer
// Revision    : 1.0
// ---------------------------------------------------------------------------
package adc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CAL   = 3'd1,
    ST_CONV  = 3'd2,
    ST_ACCUM = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Up to 8 samples are summed, so three bits of headroom cover the sum.
  localparam int c_ACC_GROWTH = 3;
  localparam int c_AVG_W      = 2;
  localparam int c_SAMP_W     = 4;

  function automatic int acc_width(input int res_w);
    return res_w + c_ACC_GROWTH;
  endfunction

  // Width of a counter that runs 0 .. max_count-1.
  function automatic int cnt_width(input int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count);
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_avg_accum.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adc_avg_accum : clear / add / shift-out accumulator for sample averaging
// Revision      : 1.0
// ---------------------------------------------------------------------------
module adc_avg_accum
  import adc_seq_pkg::*;
#(
  parameter int RES_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic               i_add,
  input  logic [RES_W-1:0]   i_sample,
  input  logic [c_AVG_W-1:0] i_shift,
  output logic [RES_W-1:0]   o_avg
);

  localparam int c_ACC_W = acc_width(RES_W);

  logic [c_ACC_W-1:0] r_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_add) begin
      r_acc <= r_acc + c_ACC_W'(i_sample);
    end
  end

  // The sum of 2^n samples shifted by n always fits back into RES_W bits.
  assign o_avg = RES_W'(r_acc >> i_shift);

endmodule
`default_nettype wire

// File: rtl/adc_seq_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adc_seq_ctrl : SAR ADC sequencer with calibration, averaging and timeout
// Revision     : 1.0
// ---------------------------------------------------------------------------
module adc_seq_ctrl
  import adc_seq_pkg::*;
#(
  parameter int RES_W      = 10,
  parameter int CAL_CYCLES = 64,
  parameter int TIMEOUT    = 1023
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start,
  input  logic             cal_req,
  input  logic             cont,
  input  logic [1:0]       avg_log2,
  output logic             adc_en,
  output logic             adc_cal,
  input  logic [RES_W-1:0] adc_result,
  input  logic             adc_valid,
  output logic [RES_W-1:0] result,
  output logic             result_valid,
  output logic             busy,
  output logic             timeout_err
);

  localparam int c_CAL_W = cnt_width(CAL_CYCLES);
  localparam int c_TO_W  = cnt_width(TIMEOUT);

  state_t                r_state;
  state_t                w_next;
  logic                  r_pend;
  logic                  r_to_err;
  logic [c_AVG_W-1:0]    r_avg;
  logic [c_SAMP_W-1:0]   r_samp_cnt;
  logic [c_CAL_W-1:0]    r_cal_cnt;
  logic [c_TO_W-1:0]     r_to_cnt;
  logic [RES_W-1:0]      r_result;
  logic [RES_W-1:0]      w_avg;
  logic [c_SAMP_W-1:0]   w_n_samples;
  logic                  w_cal_last;
  logic                  w_to_last;
  logic                  w_burst_start;
  logic                  w_take;
  logic                  w_to_hit;
  logic                  w_load;

  assign w_n_samples = c_SAMP_W'(1) << r_avg;
  assign w_cal_last  = (r_cal_cnt == c_CAL_W'(CAL_CYCLES - 1));
  assign w_to_last   = (r_to_cnt == c_TO_W'(TIMEOUT - 1));
  assign result      = r_result;
  assign timeout_err = r_to_err;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_burst_start = 1'b0;
    w_take        = 1'b0;
    w_to_hit      = 1'b0;
    w_load        = 1'b0;
    adc_en        = 1'b0;
    adc_cal       = 1'b0;
    result_valid  = 1'b0;
    busy          = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (cal_req) begin
          w_next = ST_CAL;
        end else if (start || r_pend) begin
          w_next        = ST_CONV;
          w_burst_start = 1'b1;
        end
      end
      ST_CAL: begin
        adc_cal = 1'b1;
        if (w_cal_last) begin
          w_next = ST_IDLE;
        end
      end
      ST_CONV: begin
        adc_en = 1'b1;
        // A result arriving on the final allowed cycle still wins over timeout.
        if (adc_valid) begin
          w_next = ST_ACCUM;
          w_take = 1'b1;
        end else if (w_to_last) begin
          w_next   = ST_IDLE;
          w_to_hit = 1'b1;
        end
      end
      ST_ACCUM: begin
        if (r_samp_cnt == w_n_samples) begin
          w_next = ST_DONE;
          w_load = 1'b1;
        end else begin
          w_next = ST_CONV;
        end
      end
      ST_DONE: begin
        result_valid = 1'b1;
        if (cont) begin
          w_next        = ST_CONV;
          w_burst_start = 1'b1;
        end else begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_pend   <= 1'b0;
      r_to_err <= 1'b0;
    end else begin
      if (r_state == ST_IDLE) begin
        if (cal_req && start) begin
          r_pend <= 1'b1;
        end else if (w_burst_start) begin
          r_pend <= 1'b0;
        end
      end
      if (w_to_hit) begin
        r_to_err <= 1'b1;
      end else if ((r_state == ST_IDLE) && w_burst_start) begin
        r_to_err <= 1'b0;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_cal_cnt  <= '0;
      r_to_cnt   <= '0;
      r_avg      <= '0;
      r_samp_cnt <= '0;
      r_result   <= '0;
    end else begin
      r_cal_cnt <= (r_state == ST_CAL) ? r_cal_cnt + c_CAL_W'(1) : '0;
      r_to_cnt  <= ((r_state == ST_CONV) && !adc_valid) ? r_to_cnt + c_TO_W'(1) : '0;
      if (w_burst_start) begin
        r_avg      <= avg_log2;
        r_samp_cnt <= '0;
      end else if (w_take) begin
        r_samp_cnt <= r_samp_cnt + c_SAMP_W'(1);
      end
      if (w_load) begin
        r_result <= w_avg;
      end
    end
  end

  adc_avg_accum #(
    .RES_W (RES_W)
  ) u_accum (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .i_clear  (w_burst_start),
    .i_add    (w_take),
    .i_sample (adc_result),
    .i_shift  (r_avg),
    .o_avg    (w_avg)
  );

endmodule
`default_nettype wire
